// File: rtl/sram_ctrl.sv
// Asynchronous 8-bit SRAM controller: one host request per access,
// with a programmable strobe width and a release state until i_cs drops.
module sram_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 18
) (
  input  logic              clk25mhz,
  input  logic              i_reset_n,
  input  logic              i_cs,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_dat,
  output logic [7:0]        o_dat,
  output logic              o_ack,
  output logic              o_busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_dq_o,
  input  logic [7:0]        sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_cs_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam int WEFF = (WAIT_CYCLES < 1)  ? 1  :
                        (WAIT_CYCLES > 15) ? 15 : WAIT_CYCLES;
  localparam logic [3:0] WLOAD = 4'(WEFF);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, REL
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        dqo_q, dqo_d;
  logic [7:0]        dat_q, dat_d;
  logic              cs_n_q, cs_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              dq_oe_q, dq_oe_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    dqo_d   = dqo_q;
    dat_d   = dat_q;
    unique case (state_q)
      IDLE: begin
        if (i_cs) begin
          addr_d  = i_addr;
          we_d    = i_we;
          dqo_d   = i_dat;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = WLOAD;
        state_d = STROBE;
      end
      STROBE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = HOLD;
          if (!we_q) dat_d = sram_dq_i;
        end
      end
      HOLD: state_d = REL;
      REL: begin
        if (!i_cs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin strobes decode the next state so every pad output is a flop.
  always_comb begin
    cs_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    dq_oe_d = 1'b0;
    ack_d   = 1'b0;
    busy_d  = (state_d != IDLE);
    unique case (state_d)
      SETUP: begin
        cs_n_d  = 1'b0;
        dq_oe_d = we_d;
      end
      STROBE: begin
        cs_n_d  = 1'b0;
        oe_n_d  = we_d;
        we_n_d  = !we_d;
        dq_oe_d = we_d;
      end
      HOLD: begin
        cs_n_d  = 1'b0;
        dq_oe_d = we_d;
        ack_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk25mhz) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      dqo_q   <= '0;
      dat_q   <= '0;
      cs_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      dqo_q   <= dqo_d;
      dat_q   <= dat_d;
      cs_n_q  <= cs_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      dq_oe_q <= dq_oe_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign o_dat      = dat_q;
  assign o_ack      = ack_q;
  assign o_busy     = busy_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = dqo_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_cs_n  = cs_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;

endmodule
